d_bus_arbiter: RTL and testbench
================================

// Module: d_bus_arbiter
// PURPOSE
//  Shares one data-memory port between two requesters:
//   - m0: core load/store unit.
//   - m1: debug/DMA master.
//  Both masters use the core's req/ready handshake: the req is held until a one-cycle ready.
//  Sits between the execute stage's d_* port and the SRAM/peripheral slave.
//  Grants are round-robin and locked for a whole transaction; a timeout recovers a hung slave.
// PARAMETERS
//  TIMEOUT_CYC  255           BUSY cycles without slave ready before error; 0 disables timeout
//  ERR_DATA     32'hDEAD_BEEF read data returned on timeout
// PORTS
//  clk            in   1   single clock, all logic on posedge
//  rst            in   1   synchronous, active-high reset
//  mN_addr        in   32  master N byte address (N = 0,1)
//  mN_wr_req      in   1   master N write request, held until mN_wr_ready
//  mN_be          in   4   master N byte enables
//  mN_wr_data     in   32  master N write data
//  mN_wr_ready    out  1   one-cycle write done to master N
//  mN_rd_req      in   1   master N read request, held until mN_rd_ready
//  mN_rd_ready    out  1   one-cycle read done to master N
//  mN_rd_data     out  32  read data, valid only with mN_rd_ready
//  s_addr/s_be/s_wr_data  out  32/4/32  slave request fields, muxed from the granted master
//  s_wr_req       out  1   slave write request
//  s_rd_req       out  1   slave read request
//  s_wr_ready     in   1   slave write done
//  s_rd_ready     in   1   slave read done
//  s_rd_data      in   32  slave read data
//  bus_err        out  1   one-cycle pulse on timeout
//  bus_err_id     out  1   master that timed out; holds until the next error
// BEHAVIOUR
//  - Reset: state IDLE, last_grant=1 (m0 wins first tie), timeout counter 0.
//    All ready outputs, s_*_req, bus_err and bus_err_id are 0. Reset mid-transaction
//    drops s_*_req the next cycle and issues no ready to either master.
//  - FSM states IDLE, BUSY0, BUSY1.
//    IDLE: reqN = mN_rd_req|mN_wr_req.
//      - Exactly one master requesting -> that master is granted.
//      - Both requesting -> the master != last_grant is granted.
//      - Next state is BUSYn. Arbitration costs 1 cycle; s_* are 0 in IDLE.
//    BUSYn: s_* = master n's fields, combinational.
//      - If mn_wr_req is set: s_wr_req=1, s_rd_req=0. Write has priority when a master
//        asserts both; its read remains pending as a separate later transaction.
//      - Otherwise s_rd_req=mn_rd_req.
//  - Completion: s_wr_ready/s_rd_ready in BUSYn is passed the same cycle to mn_wr_ready/mn_rd_ready.
//    s_rd_data is passed to mn_rd_data. Then last_grant<=n and the state goes to IDLE.
//    At least one IDLE cycle separates back-to-back grants.
//    The non-granted master's ready outputs stay 0 at all times.
//  - Slave ready for the request type not issued: ignored.
//  - Master drops its req while BUSYn: abort to IDLE, no ready, last_grant<=n.
//  - Timeout: an 8..32-bit counter, width $clog2(TIMEOUT_CYC+1).
//    - Counter is cleared on entry to BUSYn and increments each BUSY cycle without slave ready.
//    - When count==TIMEOUT_CYC: the issued ready pulses to master n for 1 cycle.
//      A read returns mn_rd_data=ERR_DATA.
//    - Same cycle: bus_err=1, bus_err_id<=n, state to IDLE; s_*_req are 0 from the next cycle.
//    - Slave ready in the same cycle as the timeout: the slave wins, normal completion, no error.
//  - No arithmetic on address or data: pure mux, no width conversion.
// STRUCTURE
//  - Shared package bus_pkg:
//    - typedef enum logic [1:0] {IDLE,BUSY0,BUSY1} arb_state_e;
//    - typedef struct packed {addr,be,wr_data,wr_req,rd_req} bus_req_t;
//    - localparam ERR_DATA_DEFAULT.
//  - Sub-module rr_arb2: req[1:0], last_grant -> grant_id, grant_valid (combinational picker).
//  - FSM, timeout counter and output muxes stay in d_bus_arbiter.
// TESTING
//  1. Reset, then m0_rd_req addr 0x100; slave gives s_rd_ready+0x1234_5678 two cycles after grant.
//     -> s_rd_req 1 cycle after m0 req; m0_rd_ready 1 cycle with 0x1234_5678; m1 ready stays 0.
//  2. m0 and m1 write in the same cycle, slave ready after 1 cycle each.
//     -> m0 served first, then IDLE 1 cycle, then m1; s_be/s_wr_data match each master.
//  3. Both masters requesting continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
//  4. TIMEOUT_CYC=4, m1 read, slave never ready.
//     -> m1_rd_ready after 4 BUSY cycles with 0xDEAD_BEEF; bus_err pulse; bus_err_id=1; back to IDLE.
//  5. TIMEOUT_CYC=4, slave ready exactly on cycle 4 -> normal data returned, bus_err stays 0.
//  6. rst asserted while BUSY0 with s_wr_req high.
//     -> next cycle s_wr_req=0, no m0_wr_ready; first post-reset tie goes to m0.

Source files
------------

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared types and constants for the two-master data-bus arbiter.
//   arb_state_e       : arbiter FSM states
//   bus_req_t         : one master's request fields as seen by the slave mux
//   ERR_DATA_DEFAULT  : read data returned when a transaction times out
//   cnt_width()       : timeout counter width, clamped to 8..32 bits
// ---------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wr_data;
    logic        wr_req;
    logic        rd_req;
  } bus_req_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Width needed to count up to tmo, never narrower than 8 or wider than 32.
  function automatic int unsigned cnt_width(input int unsigned tmo);
    int unsigned w;
    w = $clog2(tmo + 32'd1);
    if (w < 32'd8) begin
      w = 32'd8;
    end else if (w > 32'd32) begin
      w = 32'd32;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
//   i_req[1:0]     : per-master request
//   i_last_grant   : master served most recently
//   o_grant_id     : chosen master (valid only with o_grant_valid)
//   o_grant_valid  : at least one master is requesting
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant_id,
  output logic       o_grant_valid
);

  // Pick the lone requester, or on a tie the master not served last.
  always_comb begin
    o_grant_id    = 1'b0;
    o_grant_valid = 1'b0;
    case (i_req)
      2'b01: begin
        o_grant_id    = 1'b0;
        o_grant_valid = 1'b1;
      end
      2'b10: begin
        o_grant_id    = 1'b1;
        o_grant_valid = 1'b1;
      end
      2'b11: begin
        o_grant_id    = ~i_last_grant;
        o_grant_valid = 1'b1;
      end
      default: begin
        o_grant_id    = 1'b0;
        o_grant_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/d_bus_arbiter.sv
// ---------------------------------------------------------------------------
// d_bus_arbiter
// Shares one data-memory slave port between the core LSU (m0) and a
// debug/DMA master (m1). Grants are round-robin, locked for a whole
// transaction, and a timeout counter recovers from a hung slave.
//   i_clk, i_rst               : clock, synchronous active-high reset
//   i_mN_*                     : master N request fields (N = 0,1)
//   o_mN_wr_ready/rd_ready     : one-cycle completion pulses to master N
//   o_mN_rd_data               : read data, valid with o_mN_rd_ready
//   o_s_*                      : slave request, muxed from the granted master
//   i_s_wr_ready/rd_ready/data : slave completion and read data
//   o_bus_err, o_bus_err_id    : timeout pulse and id of the timed-out master
// ---------------------------------------------------------------------------
module d_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_m0_addr,
  input  logic        i_m0_wr_req,
  input  logic [3:0]  i_m0_be,
  input  logic [31:0] i_m0_wr_data,
  output logic        o_m0_wr_ready,
  input  logic        i_m0_rd_req,
  output logic        o_m0_rd_ready,
  output logic [31:0] o_m0_rd_data,
  input  logic [31:0] i_m1_addr,
  input  logic        i_m1_wr_req,
  input  logic [3:0]  i_m1_be,
  input  logic [31:0] i_m1_wr_data,
  output logic        o_m1_wr_ready,
  input  logic        i_m1_rd_req,
  output logic        o_m1_rd_ready,
  output logic [31:0] o_m1_rd_data,
  output logic [31:0] o_s_addr,
  output logic [3:0]  o_s_be,
  output logic [31:0] o_s_wr_data,
  output logic        o_s_wr_req,
  output logic        o_s_rd_req,
  input  logic        i_s_wr_ready,
  input  logic        i_s_rd_ready,
  input  logic [31:0] i_s_rd_data,
  output logic        o_bus_err,
  output logic        o_bus_err_id
);

  localparam int unsigned      CNT_W       = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam bit               TIMEOUT_EN  = (TIMEOUT_CYC != 32'd0);

  arb_state_e       r_state;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_id;

  bus_req_t w_m0;
  bus_req_t w_m1;
  bus_req_t w_sel;
  logic     w_id;
  logic     w_busy;
  logic     w_grant_id;
  logic     w_grant_valid;
  logic     w_wr_issue;
  logic     w_rd_issue;
  logic     w_done;
  logic     w_abort;
  logic     w_timeout;
  logic     w_wr_rdy;
  logic     w_rd_rdy;
  logic [31:0] w_rd_val;

  assign w_m0 = '{addr: i_m0_addr, be: i_m0_be, wr_data: i_m0_wr_data,
                  wr_req: i_m0_wr_req, rd_req: i_m0_rd_req};
  assign w_m1 = '{addr: i_m1_addr, be: i_m1_be, wr_data: i_m1_wr_data,
                  wr_req: i_m1_wr_req, rd_req: i_m1_rd_req};

  rr_arb2 u_rr_arb2 (
    .i_req         ({i_m1_rd_req | i_m1_wr_req, i_m0_rd_req | i_m0_wr_req}),
    .i_last_grant  (r_last_grant),
    .o_grant_id    (w_grant_id),
    .o_grant_valid (w_grant_valid)
  );

  // Select the owning master and classify this BUSY cycle's outcome.
  always_comb begin
    w_sel  = w_m0;
    w_id   = 1'b0;
    w_busy = 1'b0;
    case (r_state)
      BUSY0: begin
        w_sel  = w_m0;
        w_id   = 1'b0;
        w_busy = 1'b1;
      end
      BUSY1: begin
        w_sel  = w_m1;
        w_id   = 1'b1;
        w_busy = 1'b1;
      end
      default: begin
        w_sel  = w_m0;
        w_id   = 1'b0;
        w_busy = 1'b0;
      end
    endcase
    // Write wins when a master raises both; its read is served later.
    w_wr_issue = w_busy & w_sel.wr_req;
    w_rd_issue = w_busy & ~w_sel.wr_req & w_sel.rd_req;
    // Ready of the kind not issued is ignored.
    w_done     = (w_wr_issue & i_s_wr_ready) | (w_rd_issue & i_s_rd_ready);
    w_abort    = w_busy & ~w_sel.wr_req & ~w_sel.rd_req;
    // A slave ready in the timeout cycle takes precedence over the error.
    w_timeout  = TIMEOUT_EN & (w_wr_issue | w_rd_issue) & ~w_done &
                 (r_cnt == TIMEOUT_VAL);
    // A reset cycle never hands a ready back to a master.
    w_wr_rdy   = w_wr_issue & (w_done | w_timeout) & ~i_rst;
    w_rd_rdy   = w_rd_issue & (w_done | w_timeout) & ~i_rst;
    w_rd_val   = w_timeout ? ERR_DATA : i_s_rd_data;
  end

  // Drive slave request and master completion outputs.
  always_comb begin
    o_s_addr      = w_busy ? w_sel.addr : 32'h0;
    o_s_be        = w_busy ? w_sel.be : 4'h0;
    o_s_wr_data   = w_busy ? w_sel.wr_data : 32'h0;
    o_s_wr_req    = w_wr_issue;
    o_s_rd_req    = w_rd_issue;
    o_m0_wr_ready = w_wr_rdy & ~w_id;
    o_m0_rd_ready = w_rd_rdy & ~w_id;
    o_m1_wr_ready = w_wr_rdy & w_id;
    o_m1_rd_ready = w_rd_rdy & w_id;
    o_m0_rd_data  = (w_rd_rdy & ~w_id) ? w_rd_val : 32'h0;
    o_m1_rd_data  = (w_rd_rdy & w_id) ? w_rd_val : 32'h0;
    o_bus_err     = w_timeout & ~i_rst;
    o_bus_err_id  = r_err_id;
  end

  // Arbitration FSM, timeout counter and error id register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_err_id     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_grant_valid) begin
            r_state <= w_grant_id ? BUSY1 : BUSY0;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY0, BUSY1: begin
          if (w_abort | w_done | w_timeout) begin
            r_state      <= IDLE;
            r_last_grant <= w_id;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (w_timeout) begin
            r_err_id <= w_id;
          end else begin
            r_err_id <= r_err_id;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_bus_arbiter.sv
module tb_d_bus_arbiter;

  localparam int          TO      = 4;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m_addr [2];
  logic [3:0]  m_be   [2];
  logic [31:0] m_wd   [2];
  logic        m_wr   [2];
  logic        m_rd   [2];
  logic        m_wrdy [2];
  logic        m_rrdy [2];
  logic [31:0] m_rdat [2];
  logic [31:0] s_addr, s_wd, s_rdata;
  logic [3:0]  s_be;
  logic        s_wr_req, s_rd_req, s_wr_ready, s_rd_ready;
  logic        bus_err, bus_err_id;

  d_bus_arbiter #(.TIMEOUT_CYC(TO), .ERR_DATA(ERR_VAL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_addr(m_addr[0]), .i_m0_wr_req(m_wr[0]), .i_m0_be(m_be[0]),
    .i_m0_wr_data(m_wd[0]), .o_m0_wr_ready(m_wrdy[0]), .i_m0_rd_req(m_rd[0]),
    .o_m0_rd_ready(m_rrdy[0]), .o_m0_rd_data(m_rdat[0]),
    .i_m1_addr(m_addr[1]), .i_m1_wr_req(m_wr[1]), .i_m1_be(m_be[1]),
    .i_m1_wr_data(m_wd[1]), .o_m1_wr_ready(m_wrdy[1]), .i_m1_rd_req(m_rd[1]),
    .o_m1_rd_ready(m_rrdy[1]), .o_m1_rd_data(m_rdat[1]),
    .o_s_addr(s_addr), .o_s_be(s_be), .o_s_wr_data(s_wd),
    .o_s_wr_req(s_wr_req), .o_s_rd_req(s_rd_req),
    .i_s_wr_ready(s_wr_ready), .i_s_rd_ready(s_rd_ready), .i_s_rd_data(s_rdata),
    .o_bus_err(bus_err), .o_bus_err_id(bus_err_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // stimulus control
  int          m_left [2] = '{0, 0};
  bit          m_is_wr[2] = '{1'b0, 1'b0};
  int          slv_lat  = 0;
  bit          slv_hang = 1'b0;
  logic [31:0] slv_data = 32'h0;
  int          slv_cnt  = 0;

  // observations
  int          cyc = 0;
  int          grant_log[$];
  bit          prev_sreq = 1'b0;
  int          cur_len = 0;
  int          obs_len = 0;
  int          obs_rdy[2] = '{0, 0};
  logic [31:0] obs_data[2];
  int          obs_err = 0;
  int          t_req0 = -1;
  int          t_sreq = -1;

  // behavioural model: which master owns the bus (-1 none), who went last,
  // how many BUSY cycles have passed without a slave answer
  int   md_owner = -1;
  int   md_last  = 1;
  int   md_wait  = 0;
  logic md_err_id = 1'b0;

  function automatic void chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
  endfunction

  // Masters hold their request while transactions remain; slave answers after slv_lat.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int n = 0; n < 2; n++) begin
      m_wr[n] = (m_left[n] > 0) && m_is_wr[n];
      m_rd[n] = (m_left[n] > 0) && !m_is_wr[n];
    end
    #1;
    if (s_wr_req || s_rd_req) slv_cnt++;
    else slv_cnt = 0;
    s_wr_ready = s_wr_req && !slv_hang && (slv_cnt == slv_lat + 1);
    s_rd_ready = s_rd_req && !slv_hang && (slv_cnt == slv_lat + 1);
    s_rdata    = s_rd_ready ? slv_data : 32'h0BAD_0BAD;
  end

  // Compare DUT against the model each cycle, then advance model and observers.
  always @(negedge clk) begin
    logic [31:0] e_addr, e_wd, e_data;
    logic [3:0]  e_be;
    logic        e_swr, e_srd, e_err;
    logic        e_wrdy[2], e_rrdy[2];
    bit          fin;
    bit          sreq;
    int          n;
    e_addr = 32'h0; e_wd = 32'h0; e_be = 4'h0; e_swr = 1'b0; e_srd = 1'b0;
    e_data = 32'h0; e_err = 1'b0; fin = 1'b0;
    e_wrdy = '{1'b0, 1'b0}; e_rrdy = '{1'b0, 1'b0};
    n = (md_owner < 0) ? 0 : md_owner;
    if (md_owner >= 0) begin
      e_addr = m_addr[n]; e_be = m_be[n]; e_wd = m_wd[n];
      e_swr  = m_wr[n];
      e_srd  = !m_wr[n] && m_rd[n];
      if (!e_swr && !e_srd) fin = 1'b1;
      else if ((e_swr && s_wr_ready) || (e_srd && s_rd_ready)) begin
        fin = 1'b1; e_wrdy[n] = e_swr; e_rrdy[n] = e_srd; e_data = s_rdata;
      end else if (md_wait == TO) begin
        fin = 1'b1; e_wrdy[n] = e_swr; e_rrdy[n] = e_srd; e_data = ERR_VAL; e_err = 1'b1;
      end else md_wait++;
    end
    if (rst) begin
      e_wrdy = '{1'b0, 1'b0}; e_rrdy = '{1'b0, 1'b0}; e_err = 1'b0;
    end
    chk("s_bus", {2'b0, s_addr, s_be, s_wd, s_wr_req, s_rd_req},
                 {2'b0, e_addr, e_be, e_wd, e_swr, e_srd});
    chk("m0_ready", 72'({m_wrdy[0], m_rrdy[0]}), 72'({e_wrdy[0], e_rrdy[0]}));
    chk("m1_ready", 72'({m_wrdy[1], m_rrdy[1]}), 72'({e_wrdy[1], e_rrdy[1]}));
    chk("bus_err", 72'(bus_err), 72'(e_err));
    chk("bus_err_id", 72'(bus_err_id), 72'(md_err_id));
    for (int k = 0; k < 2; k++)
      if (e_rrdy[k]) chk(k == 0 ? "m0_rd_data" : "m1_rd_data", 72'(m_rdat[k]), 72'(e_data));
    // model state update
    if (rst) begin
      md_owner = -1; md_last = 1; md_wait = 0; md_err_id = 1'b0;
    end else if (md_owner >= 0) begin
      if (fin) begin
        md_last = md_owner; md_owner = -1;
        if (e_err) md_err_id = n[0];
      end
    end else begin
      if ((m_wr[0] || m_rd[0]) && (m_wr[1] || m_rd[1])) md_owner = 1 - md_last;
      else if (m_wr[0] || m_rd[0]) md_owner = 0;
      else if (m_wr[1] || m_rd[1]) md_owner = 1;
      md_wait = 0;
    end
    // observers (feed stimulus and the literal checks)
    sreq = s_wr_req || s_rd_req;
    if (sreq && !prev_sreq) begin
      grant_log.push_back(s_addr[9] ? 1 : 0);
      t_sreq = cyc;
    end
    if (m_rd[0] && t_req0 < 0) t_req0 = cyc;
    cur_len = sreq ? cur_len + 1 : 0;
    prev_sreq = sreq;
    if (bus_err) obs_err++;
    for (int k = 0; k < 2; k++) begin
      if (m_wrdy[k] || m_rrdy[k]) begin
        obs_rdy[k]++;
        obs_data[k] = m_rdat[k];
        obs_len = cur_len;
        if (m_left[k] > 0) m_left[k]--;
      end
    end
  end

  task automatic start(input int n, input bit is_wr, input int cnt);
    m_is_wr[n] = is_wr;
    m_left[n]  = cnt;
  endtask

  task automatic run_txn(input string name, input int budget);
    int k = 0;
    while ((m_left[0] > 0 || m_left[1] > 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    checks++;
    if (m_left[0] == 0 && m_left[1] == 0) passes++;
    else begin
      $display("FAIL %s_done left0=%0d left1=%0d required 0 within %0d cycles",
               name, m_left[0], m_left[1], budget);
      m_left[0] = 0; m_left[1] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic chk_log(input string name, input int exp[$]);
    string g, e;
    g = ""; e = "";
    foreach (grant_log[i]) g = {g, $sformatf("%0d", grant_log[i])};
    foreach (exp[i]) e = {e, $sformatf("%0d", exp[i])};
    checks++;
    if (g == e) passes++;
    else $display("FAIL %s got=%s expected=%s", name, g, e);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    m_addr = '{32'h0000_0100, 32'h0000_0200};
    m_be   = '{4'b0011, 4'b1100};
    m_wd   = '{32'hA5A5_0000, 32'h0000_5A5A};
    m_wr   = '{1'b0, 1'b0};
    m_rd   = '{1'b0, 1'b0};
    s_wr_ready = 1'b0; s_rd_ready = 1'b0; s_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_s_req", 72'({s_wr_req, s_rd_req}), 72'd0);
    chk("reset_err", 72'({bus_err, bus_err_id}), 72'd0);
    #1;

    // 1: single m0 read, slave answers two cycles after grant
    slv_lat = 2; slv_data = 32'h1234_5678;
    start(0, 1'b0, 1);
    run_txn("t1", 20);
    chk("t1_data", 72'(obs_data[0]), 72'h1234_5678);
    chk("t1_latency", 72'(t_sreq - t_req0), 72'd1);
    chk("t1_busy_len", 72'(obs_len), 72'd3);
    chk("t1_m1_ready", 72'(obs_rdy[1]), 72'd0);

    // 2: simultaneous writes from a fresh reset -> m0 first
    pulse_reset();
    grant_log.delete();
    slv_lat = 1;
    start(0, 1'b1, 1); start(1, 1'b1, 1);
    run_txn("t2", 30);
    chk_log("t2_order", '{0, 1});

    // 3: both masters streaming reads -> strict alternation
    grant_log.delete();
    slv_lat = 0; slv_data = 32'h0F0F_1234;
    start(0, 1'b0, 3); start(1, 1'b0, 3);
    run_txn("t3", 60);
    chk_log("t3_order", '{0, 1, 0, 1, 0, 1});

    // 4: m1 read against a dead slave -> timeout
    obs_err = 0; slv_hang = 1'b1;
    start(1, 1'b0, 1);
    run_txn("t4", 30);
    chk("t4_data", 72'(obs_data[1]), 72'(ERR_VAL));
    chk("t4_err_cnt", 72'(obs_err), 72'd1);
    chk("t4_err_id", 72'(bus_err_id), 72'd1);
    chk("t4_busy_len", 72'(obs_len), 72'(TO + 1));

    // 5: slave answers in the very cycle the timeout would fire
    obs_err = 0; slv_hang = 1'b0; slv_lat = TO; slv_data = 32'hCAFE_0005;
    start(0, 1'b0, 1);
    run_txn("t5", 30);
    chk("t5_data", 72'(obs_data[0]), 72'hCAFE_0005);
    chk("t5_err_cnt", 72'(obs_err), 72'd0);
    chk("t5_err_id_hold", 72'(bus_err_id), 72'd1);

    // 6: reset in the middle of an m0 write, then a tie
    grant_log.delete();
    slv_hang = 1'b1; slv_lat = 0;
    start(0, 1'b1, 1);
    begin
      int k = 0;
      while (!s_wr_req && k < 10) begin @(negedge clk); k++; end
    end
    chk("t6_busy", 72'(s_wr_req), 72'd1);
    start(1, 1'b1, 1);
    obs_rdy[0] = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; slv_hang = 1'b0;
    @(negedge clk);
    chk("t6_no_ready", 72'(obs_rdy[0]), 72'd0);
    chk("t6_s_wr_drop", 72'(s_wr_req), 72'd0);
    #1;
    run_txn("t6", 30);
    chk_log("t6_order", '{0, 0, 1});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
